// File: rtl/status_register_unit.sv
// NZCV status register with multiply-return tracking and ID flag-hazard stall.
// Optional STATUS_BYPASS_EN forwards same-cycle flag writes to status_out and relaxes the stall.
module status_register_unit #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             alu_wr,
    input  logic [3:0]       alu_flags,
    input  logic             mul_issue,
    input  logic             mul_flags_valid,
    input  logic [3:0]       mul_flags,
    input  logic             id_needs_flags,
    output logic [3:0]       status_out,
    output logic             flags_stall,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             err_sticky
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PENDING);

    logic [3:0]       flagsQ, flagsD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             errQ, errD;
    logic             cntZero, cntFull, mulAccept, unresolved;

    assign cntZero   = (cntQ == '0);
    assign cntFull   = (cntQ == MaxCnt);
    // A return with nothing outstanding is a protocol error and never touches the flags.
    assign mulAccept = mul_flags_valid & ~cntZero;

    always_comb begin
        flagsD = flagsQ;
        cntD   = cntQ;
        errD   = errQ;
        if (flush) begin
            // The ALU instruction in EXE is older than the flush point, so it still commits.
            if (alu_wr) flagsD = alu_flags;
            cntD = '0;
        end else if (!freeze) begin
            if (alu_wr)         flagsD = alu_flags;
            else if (mulAccept) flagsD = mul_flags;
            unique case ({mul_issue, mulAccept})
                2'b10: begin
                    if (cntFull) errD = 1'b1;
                    else         cntD = cntQ + 1'b1;
                end
                2'b01:   cntD = cntQ - 1'b1;
                default: cntD = cntQ;
            endcase
            if (mul_flags_valid && cntZero) errD = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flagsQ <= 4'b0000;
            cntQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            flagsQ <= flagsD;
            cntQ   <= cntD;
            errQ   <= errD;
        end
    end

`ifdef STATUS_BYPASS_EN
    logic [CNT_W-1:0] cntAfter;
    assign cntAfter   = cntQ - CNT_W'(mulAccept);
    assign status_out = alu_wr ? alu_flags : (mulAccept ? mul_flags : flagsQ);
    assign unresolved = (cntAfter != '0) | mul_issue;
`else
    // Without forwarding, ID must wait for any flag write in EXE to land in flagsQ.
    assign status_out = flagsQ;
    assign unresolved = ~cntZero | mul_issue | alu_wr | mul_flags_valid;
`endif

    assign flags_stall = id_needs_flags & unresolved & ~flush;
    assign pending_cnt = cntQ;
    assign err_sticky  = errQ;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed bench for status_register_unit: flag ordering, multiply tracking, stall, flush/freeze.
module tb_status_register_unit;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             freeze, flush, alu_wr, mul_issue, mul_flags_valid, id_needs_flags;
    logic [3:0]       alu_flags, mul_flags;
    logic [3:0]       status_out;
    logic             flags_stall;
    logic [CNT_W-1:0] pending_cnt;
    logic             err_sticky;

    int passCnt  = 0;
    int checkCnt = 0;

    logic [3:0] exp_q[$];
    string      tagQ[$];

    status_register_unit #(.MAX_PENDING(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .alu_wr(alu_wr), .alu_flags(alu_flags),
        .mul_issue(mul_issue), .mul_flags_valid(mul_flags_valid), .mul_flags(mul_flags),
        .id_needs_flags(id_needs_flags),
        .status_out(status_out), .flags_stall(flags_stall),
        .pending_cnt(pending_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [3:0] exp);
        exp_q.push_back(exp);
        tagQ.push_back(tag);
    endtask

    task automatic popCheck();
        logic [3:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            check("sb_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            t = tagQ.pop_front();
            check(t, {4'b0, status_out}, {4'b0, e});
        end
    endtask

    task automatic clearIn();
        freeze = 0; flush = 0; alu_wr = 0; alu_flags = 0;
        mul_issue = 0; mul_flags_valid = 0; mul_flags = 0; id_needs_flags = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
        clearIn();
    endtask

    initial begin
        clearIn();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_status", {4'b0, status_out}, 8'h00);
        check("reset_cnt", {5'b0, pending_cnt}, 8'd0);
        check("reset_err", {7'b0, err_sticky}, 8'd0);

        // Build non-reset state, then pulse rst between edges.
        alu_wr = 1; alu_flags = 4'b1010; mul_flags_valid = 1; mul_flags = 4'b0101;
        step();
        mul_issue = 1;
        step();
        check("pre_rst_status", {4'b0, status_out}, 8'h0A);
        check("pre_rst_cnt", {5'b0, pending_cnt}, 8'd1);
        check("pre_rst_err", {7'b0, err_sticky}, 8'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_status", {4'b0, status_out}, 8'h00);
        check("async_rst_cnt", {5'b0, pending_cnt}, 8'd0);
        check("async_rst_err", {7'b0, err_sticky}, 8'd0);
        rst = 1'b0;
        step();

        // ALU write.
        id_needs_flags = 1; alu_wr = 1; alu_flags = 4'b0100;
        #1;
`ifdef STATUS_BYPASS_EN
        check("alu_bypass_status", {4'b0, status_out}, 8'h04);
        check("alu_stall", {7'b0, flags_stall}, 8'd0);
`else
        check("alu_stall", {7'b0, flags_stall}, 8'd1);
`endif
        push("alu_write", 4'b0100);
        step();
        popCheck();
        id_needs_flags = 1;
        #1 check("alu_stall_after", {7'b0, flags_stall}, 8'd0);

        // Two multiplies returning in order.
        id_needs_flags = 1; mul_issue = 1;
        #1 check("mul_issue_stall", {7'b0, flags_stall}, 8'd1);
        step();
        id_needs_flags = 1; mul_issue = 1;
        step();
        check("mul_cnt2", {5'b0, pending_cnt}, 8'd2);
        id_needs_flags = 1;
        #1 check("mul_cnt2_stall", {7'b0, flags_stall}, 8'd1);
        mul_flags_valid = 1; mul_flags = 4'b1000;
        #1 check("mul_ret1_stall", {7'b0, flags_stall}, 8'd1);
        push("mul_ret1", 4'b1000);
        step();
        popCheck();
        id_needs_flags = 1; mul_flags_valid = 1; mul_flags = 4'b0001;
        #1;
`ifdef STATUS_BYPASS_EN
        check("mul_ret2_stall", {7'b0, flags_stall}, 8'd0);
`else
        check("mul_ret2_stall", {7'b0, flags_stall}, 8'd1);
`endif
        push("mul_ret2", 4'b0001);
        step();
        popCheck();
        check("mul_cnt0", {5'b0, pending_cnt}, 8'd0);
        id_needs_flags = 1;
        #1 check("mul_done_stall", {7'b0, flags_stall}, 8'd0);

        // Simultaneous writers: the ALU result is younger and wins.
        mul_issue = 1;
        step();
        alu_wr = 1; alu_flags = 4'b0010; mul_flags_valid = 1; mul_flags = 4'b1001;
        push("both_writers", 4'b0010);
        step();
        popCheck();
        check("both_cnt", {5'b0, pending_cnt}, 8'd0);
        mul_issue = 1;
        step();
        mul_issue = 1; mul_flags_valid = 1; mul_flags = 4'b0111;
        push("issue_and_return", 4'b0111);
        step();
        popCheck();
        check("issue_ret_cnt", {5'b0, pending_cnt}, 8'd1);
        check("issue_ret_err", {7'b0, err_sticky}, 8'd0);
        mul_flags_valid = 1; mul_flags = 4'b0011;
        step();

        // Overflow: MAX_PENDING+1 issues.
        for (int i = 0; i < 4; i++) begin
            mul_issue = 1;
            step();
        end
        check("full_cnt", {5'b0, pending_cnt}, 8'd4);
        check("full_err", {7'b0, err_sticky}, 8'd0);
        mul_issue = 1;
        step();
        check("ovf_cnt", {5'b0, pending_cnt}, 8'd4);
        check("ovf_err", {7'b0, err_sticky}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            mul_flags_valid = 1; mul_flags = 4'($urandom_range(0, 15));
            if (i == 3) mul_flags = 4'b0110;
            step();
        end
        push("drain_last", 4'b0110);
        popCheck();
        mul_flags_valid = 1; mul_flags = 4'b1001;
        push("underflow_ignored", 4'b0110);
        step();
        popCheck();
        check("udf_cnt", {5'b0, pending_cnt}, 8'd0);
        check("udf_err", {7'b0, err_sticky}, 8'd1);

        // Flush at cnt=3 with an older ALU write.
        repeat (3) begin
            mul_issue = 1;
            step();
        end
        check("pre_flush_cnt", {5'b0, pending_cnt}, 8'd3);
        flush = 1; freeze = 1; alu_wr = 1; alu_flags = 4'b1100;
        mul_issue = 1; mul_flags_valid = 1; mul_flags = 4'b0001; id_needs_flags = 1;
        #1 check("flush_stall", {7'b0, flags_stall}, 8'd0);
        push("flush_alu", 4'b1100);
        step();
        popCheck();
        check("flush_cnt", {5'b0, pending_cnt}, 8'd0);

        // Freeze drops every input.
        freeze = 1; alu_wr = 1; alu_flags = 4'b0011; mul_issue = 1;
        push("freeze_hold", 4'b1100);
        step();
        popCheck();
        check("freeze_cnt", {5'b0, pending_cnt}, 8'd0);
        check("freeze_err", {7'b0, err_sticky}, 8'd1);

        check("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
